debounced_code_decoder: RTL and testbench

Parametrised successor to the team's fixed 4-input code decoder. An IN_W-bit code from board switches or buttons is synchronised to clk, debounced as a whole bus, and decoded into a registered one-hot bus of NUM_OUT lines. It also emits a one-cycle change strobe and an out-of-range flag. Sits between raw Mojo I/O pins and the LED and control logic in the top level.

---
 rtl/debounced_code_decoder_pkg.sv | 22 ++
 rtl/debounced_code_decoder_if.sv | 30 +++
 rtl/debounced_code_decoder_bus_debouncer.sv | 44 ++++
 rtl/debounced_code_decoder.sv | 57 +++++
 tb/tb_debounced_code_decoder.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/debounced_code_decoder_pkg.sv
// rtl/debounced_code_decoder_pkg.sv - shared constants and helpers for the code decoder
package debounced_code_decoder_pkg;

    // 1 ms at the 50 MHz board clock
    localparam int DEFAULT_DEBOUNCE_1MS = 50000;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/debounced_code_decoder_if.sv
// rtl/debounced_code_decoder_if.sv - code input / decoded output bundle
interface debounced_code_decoder_if #(
    parameter int IN_W    = 4,
    parameter int NUM_OUT = 16
);
    logic [IN_W-1:0]    code_in;
    logic               en;
    logic [NUM_OUT-1:0] onehot_out;
    logic [IN_W-1:0]    code_out;
    logic               changed;
    logic               invalid;

    modport master (
        output code_in,
        output en,
        input  onehot_out,
        input  code_out,
        input  changed,
        input  invalid
    );

    modport slave (
        input  code_in,
        input  en,
        output onehot_out,
        output code_out,
        output changed,
        output invalid
    );
endinterface

// File: rtl/debounced_code_decoder_bus_debouncer.sv
// rtl/debounced_code_decoder_bus_debouncer.sv - two-flop synchroniser plus whole-bus debounce counter
module bus_debouncer
    import debounced_code_decoder_pkg::*;
#(
    parameter int W               = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_1MS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] raw,
    output logic [W-1:0] stable,
    output logic         settled
);
    localparam int               CNT_W   = clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [W-1:0]     sync1;
    logic [W-1:0]     sync2;
    logic [W-1:0]     candidate;
    logic [CNT_W-1:0] counter;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            candidate <= '0;
            counter   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // any bit moving restarts the count for the whole bus
            if (sync2 != candidate) begin
                candidate <= sync2;
                counter   <= '0;
            end else if (counter != CNT_MAX) begin
                counter <= counter + 1'b1;
            end
        end
    end

    assign stable  = candidate;
    assign settled = (counter == CNT_MAX) && (sync2 == candidate);

endmodule

// File: rtl/debounced_code_decoder.sv
// rtl/debounced_code_decoder.sv - debounced bus decoded into a registered one-hot with change strobe
module debounced_code_decoder
    import debounced_code_decoder_pkg::*;
#(
    parameter int IN_W            = 4,
    parameter int NUM_OUT         = 16,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_1MS
) (
    input  logic                     clk,
    input  logic                     rst,
    debounced_code_decoder_if.slave  bus
);
    logic [IN_W-1:0]    stable;
    logic               settled;
    logic               commit;
    logic [NUM_OUT-1:0] decoded;
    logic               out_of_range;

    bus_debouncer #(
        .W               (IN_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk     (clk),
        .rst     (rst),
        .raw     (bus.code_in),
        .stable  (stable),
        .settled (settled)
    );

    always_comb begin
        decoded = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            decoded[i] = (int'(stable) == i);
        end
    end

    assign out_of_range = (int'(stable) >= NUM_OUT);
    // a settled code equal to the one already shown is not a change
    assign commit       = settled && (stable != bus.code_out) && bus.en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.code_out   <= '0;
            bus.onehot_out <= NUM_OUT'(1);
            bus.changed    <= 1'b0;
            bus.invalid    <= 1'b0;
        end else begin
            bus.changed <= commit;
            if (commit) begin
                bus.code_out   <= stable;
                bus.onehot_out <= decoded;
                bus.invalid    <= out_of_range;
            end
        end
    end

endmodule

// File: tb/tb_debounced_code_decoder.sv
// tb/tb_debounced_code_decoder.sv - directed checks of debounce, decode, enable and async reset
module tb_debounced_code_decoder;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    debounced_code_decoder_if #(.IN_W(4), .NUM_OUT(16)) ia ();
    debounced_code_decoder_if #(.IN_W(4), .NUM_OUT(10)) ib ();

    debounced_code_decoder #(.IN_W(4), .NUM_OUT(16), .DEBOUNCE_CYCLES(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia)
    );

    debounced_code_decoder #(.IN_W(4), .NUM_OUT(10), .DEBOUNCE_CYCLES(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib)
    );

    int checks = 0;
    int errors = 0;
    int pulses;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        ia.code_in = 4'h5;
        ia.en      = 1'b1;
        ib.code_in = 4'h0;
        ib.en      = 1'b1;
        rst        = 1'b1;
        #2;
        check("reset_onehot", 32'(ia.onehot_out), 32'h0001);
        check("reset_code", 32'(ia.code_out), 32'h0);
        check("reset_changed", 32'(ia.changed), 32'h0);
        check("reset_invalid", 32'(ia.invalid), 32'h0);
        tick(2);
        rst = 1'b0;

        // 1: held code 5 accepted on edge 7 after reset release
        for (int e = 1; e <= 6; e++) begin
            tick();
            check($sformatf("t1_hold_e%0d", e), 32'(ia.onehot_out), 32'h0001);
            check($sformatf("t1_nochg_e%0d", e), 32'(ia.changed), 32'h0);
        end
        tick();
        check("t1_onehot", 32'(ia.onehot_out), 32'h0020);
        check("t1_code", 32'(ia.code_out), 32'h5);
        check("t1_changed", 32'(ia.changed), 32'h1);
        check("t1_invalid", 32'(ia.invalid), 32'h0);
        tick();
        check("t1_changed_drop", 32'(ia.changed), 32'h0);

        // 2: two-cycle glitch to 9 is ignored
        ia.code_in = 4'h9;
        tick(2);
        ia.code_in = 4'h5;
        pulses = 0;
        repeat (12) begin
            tick();
            pulses += int'(ia.changed);
        end
        check("t2_pulses", 32'(pulses), 32'h0);
        check("t2_onehot", 32'(ia.onehot_out), 32'h0020);

        // 3: out-of-range code on a 10-output decoder
        ib.code_in = 4'hC;
        tick(6);
        check("t3_pre_onehot", 32'(ib.onehot_out), 32'h001);
        tick();
        check("t3_onehot", 32'(ib.onehot_out), 32'h000);
        check("t3_invalid", 32'(ib.invalid), 32'h1);
        check("t3_changed", 32'(ib.changed), 32'h1);
        check("t3_code", 32'(ib.code_out), 32'hC);
        ib.code_in = 4'h3;
        tick(7);
        check("t3b_onehot", 32'(ib.onehot_out), 32'h008);
        check("t3b_invalid", 32'(ib.invalid), 32'h0);
        check("t3b_changed", 32'(ib.changed), 32'h1);

        // 4: enable low holds outputs; commit on the edge after en rises
        ia.code_in = 4'h3;
        tick(7);
        check("t4_pre_onehot", 32'(ia.onehot_out), 32'h0008);
        check("t4_pre_changed", 32'(ia.changed), 32'h1);
        ia.en      = 1'b0;
        ia.code_in = 4'h7;
        pulses     = 0;
        repeat (20) begin
            tick();
            pulses += int'(ia.changed);
        end
        check("t4_hold_pulses", 32'(pulses), 32'h0);
        check("t4_hold_code", 32'(ia.code_out), 32'h3);
        ia.en = 1'b1;
        tick();
        check("t4_code", 32'(ia.code_out), 32'h7);
        check("t4_onehot", 32'(ia.onehot_out), 32'h0080);
        check("t4_changed", 32'(ia.changed), 32'h1);
        tick();
        check("t4_changed_drop", 32'(ia.changed), 32'h0);

        // 5: async reset mid-debounce clears outputs without a clock edge
        ia.code_in = 4'hA;
        tick(5);
        #3;
        rst = 1'b1;
        #1;
        check("t5_onehot", 32'(ia.onehot_out), 32'h0001);
        check("t5_code", 32'(ia.code_out), 32'h0);
        check("t5_invalid", 32'(ia.invalid), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(6);
        check("t5_pending_onehot", 32'(ia.onehot_out), 32'h0001);
        check("t5_pending_code", 32'(ia.code_out), 32'h0);
        tick();
        check("t5_reaccept_onehot", 32'(ia.onehot_out), 32'h0400);
        check("t5_reaccept_code", 32'(ia.code_out), 32'hA);

        // 6: bit toggling every 3 cycles never settles; final value commits once
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            if (i % 3 == 0) begin
                ia.code_in = ia.code_in ^ 4'h1;
            end
            tick();
            pulses += int'(ia.changed);
        end
        check("t6_toggle_pulses", 32'(pulses), 32'h0);
        check("t6_toggle_code", 32'(ia.code_out), 32'hA);
        pulses = 0;
        repeat (20) begin
            tick();
            pulses += int'(ia.changed);
        end
        check("t6_hold_pulses", 32'(pulses), 32'h1);
        check("t6_hold_code", 32'(ia.code_out), 32'hB);
        check("t6_hold_onehot", 32'(ia.onehot_out), 32'h0800);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
